instr_fetch: RTL and testbench

Fetch stage directly downstream of the 64x16 instruction ROM. It consumes the ROM's packed word array and holds a 6-bit PC. Each cycle it presents one instruction plus its PC to decode over a valid/ready handshake. It supports branch redirect from execute and stops fetching after a HALT word is accepted.

---
 rtl/instr_fetch_pkg.sv | 20 ++
 rtl/instr_fetch.sv | 112 +++++++++++
 tb/tb_instr_fetch.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage definitions: widths, HALT encoding, PC/instruction types
// and the fetch FSM state encoding.
package fetch_pkg;

  localparam int unsigned AW = 6;
  localparam int unsigned IW = 16;
  localparam int unsigned CW = 16;
  localparam int unsigned DEPTH = 2 ** AW;

  localparam logic [IW-1:0] HALT_WORD = 16'hE000;

  typedef logic [AW-1:0] pc_t;
  typedef logic [IW-1:0] instr_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: reads the instruction ROM at pc_q and presents one instruction
// plus its PC to decode per cycle over valid/ready. Supports branch redirect
// and stops fetching once a HALT word is accepted.
//
// Ports:
//   clk            clock, all state on rising edge
//   reset          synchronous active-high reset
//   imem_i         ROM contents, packed word array indexed by PC
//   ready_i        decode can take an instruction this cycle
//   redirect_i     branch taken: flush and refetch from redirect_pc_i
//   redirect_pc_i  branch target address
//   instr_o        instruction presented to decode
//   pc_o           address of instr_o
//   valid_o        instr_o/pc_o valid
//   halted_o       fetch stopped on HALT_WORD
//   fetch_count_o  saturating count of accepted instructions
module instr_fetch
  import fetch_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DEPTH-1:0][IW-1:0]     imem_i,
  input  logic                         ready_i,
  input  logic                         redirect_i,
  input  logic [AW-1:0]                redirect_pc_i,
  output logic [IW-1:0]                instr_o,
  output logic [AW-1:0]                pc_o,
  output logic                         valid_o,
  output logic                         halted_o,
  output logic [CW-1:0]                fetch_count_o
);

  fetch_state_t state_q, state_d;
  pc_t          pc_q, pc_d;
  instr_t       instr_d;
  pc_t          pc_out_d;
  logic         valid_d;
  logic         halted_d;
  logic [CW-1:0] count_d;

  logic accept;
  logic slot_free;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      pc_q          <= '0;
      instr_o       <= '0;
      pc_o          <= '0;
      valid_o       <= 1'b0;
      halted_o      <= 1'b0;
      fetch_count_o <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_o       <= instr_d;
      pc_o          <= pc_out_d;
      valid_o       <= valid_d;
      halted_o      <= halted_d;
      fetch_count_o <= count_d;
    end
  end

  // Next-state: redirect beats accept/load, which beats hold.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_o;
    pc_out_d  = pc_o;
    valid_d   = valid_o;
    halted_d  = halted_o;
    count_d   = fetch_count_o;

    accept    = valid_o && ready_i;
    slot_free = !valid_o || ready_i;

    // Accepts count even in a redirect cycle; saturate instead of wrapping.
    if (accept && (fetch_count_o != {CW{1'b1}})) begin
      count_d = fetch_count_o + CW'(1);
    end

    if (redirect_i) begin
      pc_d     = redirect_pc_i;
      valid_d  = 1'b0;
      state_d  = RUN;
      halted_d = 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (accept && (instr_o == HALT_WORD)) begin
            state_d  = HALTED;
            halted_d = 1'b1;
            valid_d  = 1'b0;
          end else if (slot_free) begin
            instr_d  = imem_i[pc_q];
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + AW'(1);
          end
        end
        HALTED: begin
          valid_d = 1'b0;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: startup latency, backpressure hold,
// redirect, HALT, PC wrap, mid-run reset and counter saturation.
module tb_instr_fetch;
  import fetch_pkg::*;

  logic                     clk;
  logic                     reset;
  logic [DEPTH-1:0][IW-1:0] imem;
  logic                     ready;
  logic                     redirect;
  logic [AW-1:0]            redirect_pc;
  logic [IW-1:0]            instr;
  logic [AW-1:0]            pc;
  logic                     valid;
  logic                     halted;
  logic [CW-1:0]            fetch_count;

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .imem_i        (imem),
    .ready_i       (ready),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_o       (instr),
    .pc_o          (pc),
    .valid_o       (valid),
    .halted_o      (halted),
    .fetch_count_o (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; leave the bench at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic v, input logic [AW-1:0] p,
                           input logic [IW-1:0] ins, input logic [CW-1:0] cnt);
    check({tag, ".valid"}, 32'(valid), 32'(v));
    check({tag, ".pc"}, 32'(pc), 32'(p));
    check({tag, ".instr"}, 32'(instr), 32'(ins));
    check({tag, ".count"}, 32'(fetch_count), 32'(cnt));
  endtask

  initial begin
    // ROM image: distinctive words at 0, 5, 12; the rest {i, i}, never HALT.
    for (int i = 0; i < DEPTH; i++) imem[i] = {8'(i), 8'(i)};
    imem[0]  = 16'h4139;
    imem[5]  = 16'h19B3;
    imem[12] = 16'hB0A0;

    reset = 1'b1; ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    @(negedge clk);
    step();
    check("rst.valid", 32'(valid), 32'd0);
    check("rst.count", 32'(fetch_count), 32'd0);
    reset = 1'b0;

    // Startup and streaming.
    step(); check_out("boot0", 1'b1, 6'd0, 16'h4139, 16'd0);
    step(); check_out("boot1", 1'b1, 6'd1, 16'h0101, 16'd1);
    step(); check_out("boot2", 1'b1, 6'd2, 16'h0202, 16'd2);
    step(); check_out("boot3", 1'b1, 6'd3, 16'h0303, 16'd3);

    // Redirect to 12 while pc 3 is accepted.
    redirect = 1'b1; redirect_pc = 6'd12;
    step(); redirect = 1'b0;
    check("redir.valid", 32'(valid), 32'd0);
    check("redir.count", 32'(fetch_count), 32'd4);
    step(); check_out("redir12", 1'b1, 6'd12, 16'hB0A0, 16'd4);
    step(); check_out("redir13", 1'b1, 6'd13, 16'h0D0D, 16'd5);

    // Reach pc 5, then backpressure for 3 cycles.
    redirect = 1'b1; redirect_pc = 6'd4;
    step(); redirect = 1'b0;
    step(); check_out("to4", 1'b1, 6'd4, 16'h0404, 16'd6);
    step(); check_out("to5", 1'b1, 6'd5, 16'h19B3, 16'd7);
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(); check_out("hold", 1'b1, 6'd5, 16'h19B3, 16'd7);
    end
    ready = 1'b1;
    step(); check_out("unhold", 1'b1, 6'd6, 16'h0606, 16'd8);

    // HALT at 17.
    imem[17] = HALT_WORD;
    redirect = 1'b1; redirect_pc = 6'd16;
    step(); redirect = 1'b0;
    check("h.flush", 32'(valid), 32'd0);
    step(); check_out("h16", 1'b1, 6'd16, 16'h1010, 16'd9);
    step(); check_out("h17", 1'b1, 6'd17, 16'hE000, 16'd10);
    for (int k = 0; k < 10; k++) begin
      step();
      check("halt.halted", 32'(halted), 32'd1);
      check("halt.valid", 32'(valid), 32'd0);
    end
    check("halt.count", 32'(fetch_count), 32'd11);
    redirect = 1'b1; redirect_pc = 6'd0;
    step(); redirect = 1'b0;
    check("unhalt.halted", 32'(halted), 32'd0);
    check("unhalt.valid", 32'(valid), 32'd0);
    step(); check_out("unhalt0", 1'b1, 6'd0, 16'h4139, 16'd11);

    // PC wrap 62, 63, 0, 1 with no bubble.
    redirect = 1'b1; redirect_pc = 6'd62;
    step(); redirect = 1'b0;
    step(); check_out("w62", 1'b1, 6'd62, 16'h3E3E, 16'd12);
    step(); check_out("w63", 1'b1, 6'd63, 16'h3F3F, 16'd13);
    step(); check_out("w0", 1'b1, 6'd0, 16'h4139, 16'd14);
    step(); check_out("w1", 1'b1, 6'd1, 16'h0101, 16'd15);

    // Reset while pc 9 is held.
    redirect = 1'b1; redirect_pc = 6'd8;
    step(); redirect = 1'b0;
    step(); check_out("r8", 1'b1, 6'd8, 16'h0808, 16'd16);
    step(); check_out("r9", 1'b1, 6'd9, 16'h0909, 16'd17);
    ready = 1'b0; reset = 1'b1;
    step();
    check_out("mrst", 1'b0, 6'd0, 16'h0000, 16'd0);
    check("mrst.halted", 32'(halted), 32'd0);
    reset = 1'b0; ready = 1'b1;
    imem[17] = 16'h1111;
    step(); check_out("rel0", 1'b1, 6'd0, 16'h4139, 16'd0);

    // Counter saturation: stream until the count reaches all-ones.
    for (int k = 0; k < 65535; k++) step();
    check("sat.full", 32'(fetch_count), 32'hFFFF);
    check("sat.valid", 32'(valid), 32'd1);
    step();
    check("sat.hold", 32'(fetch_count), 32'hFFFF);
    check("sat.valid2", 32'(valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
